countdown_subtractor: RTL



---
 rtl/countdown_subtractor_pkg.sv | 12 +
 rtl/countdown_subtractor_fourbit.sv | 29 ++
 rtl/countdown_subtractor.sv | 95 +++++++++
 3 files changed

// File: rtl/countdown_subtractor_pkg.sv
// rtl/countdown_subtractor_pkg.sv - shared width and FSM state encodings for the countdown counter
package countdown_subtractor_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_subtractor_fourbit.sv
// rtl/countdown_subtractor_fourbit.sv - 4-bit ripple subtractor, Bout=1 means A>=B (no borrow)
module fourbitSubtractor
    import countdown_subtractor_pkg::*;
(
    output logic [CNT_W-1:0] S,
    output logic             Bout,
    input  logic [CNT_W-1:0] A,
    input  logic [CNT_W-1:0] B,
    input  logic             Cin
);

    // A - B computed as A + ~B + Cin; the final carry is the inverted borrow
    logic [CNT_W:0]   w_carry;
    logic [CNT_W-1:0] w_b_inv;

    assign w_carry[0] = Cin;
    assign w_b_inv    = ~B;

    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_bit
            assign S[gi]         = A[gi] ^ w_b_inv[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (A[gi] & w_b_inv[gi]) | (w_carry[gi] & (A[gi] ^ w_b_inv[gi]));
        end
    endgenerate

    assign Bout = w_carry[CNT_W];

endmodule

// File: rtl/countdown_subtractor.sv
// rtl/countdown_subtractor.sv - loadable programmable-step down-counter with run/pause/done FSM
module countdown_subtractor
    import countdown_subtractor_pkg::*;
#(
    parameter int WRAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] step_val,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_borrow;
    logic             w_borrow_nxt;
    logic [CNT_W-1:0] w_diff;
    logic             w_no_borrow;

    fourbitSubtractor u_sub (
        .S    (w_diff),
        .Bout (w_no_borrow),
        .A    (r_count),
        .B    (step_val),
        .Cin  (1'b1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_borrow_nxt = r_borrow;
        if (load) begin
            w_count_nxt  = load_val;
            w_borrow_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_borrow_nxt = 1'b0;
                        w_state_nxt  = (r_count != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (!pause) begin
                        if (w_no_borrow) begin
                            w_count_nxt = w_diff;
                            if (w_diff == '0) begin
                                w_state_nxt = ST_DONE;
                            end
                        end else if (WRAP != 0) begin
                            // the subtractor output is already the modulo-16 result
                            w_count_nxt  = w_diff;
                            w_borrow_nxt = 1'b1;
                        end else begin
                            w_count_nxt  = '0;
                            w_borrow_nxt = 1'b1;
                            w_state_nxt  = ST_DONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign count  = r_count;
    assign borrow = r_borrow;
    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_DONE);

endmodule
